// File: rtl/data_mem_resp.sv
// data_mem_resp: data-memory responder for the single-cycle RISC-V core.
// Holds RAM_WORDS words of RAM plus a memory-mapped register window:
//   word 0xF0 GPIO_OUT (r/w), 0xF1 CYCLE (ro), 0xF2 ACCESS (ro),
//   word 0xF3 STATUS (write-1-to-clear error flags).
// Loads are combinational; stores, counters and status update on the
// rising edge of clk.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   data_cen   in   chip enable, active-low (1 = idle)
//   data_wen   in   write enable, active-low (0 = store, 1 = load)
//   data_addr  in   10-bit byte address, word index is data_addr[9:2]
//   wdata      in   32-bit store data
//   rdata      out  32-bit load data, combinational
//   gpio_out   out  GPIO_W-bit GPIO output register
//   err_irq    out  registered OR of the STATUS bits
module data_mem_resp #(
  parameter int RAM_WORDS = 240,
  parameter int GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              data_cen,
  input  logic              data_wen,
  input  logic [9:0]        data_addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              err_irq
);

  localparam int RAM_IDX_W = $clog2(RAM_WORDS);

  localparam logic [7:0] IDX_GPIO   = 8'hF0;
  localparam logic [7:0] IDX_CYCLE  = 8'hF1;
  localparam logic [7:0] IDX_ACCESS = 8'hF2;
  localparam logic [7:0] IDX_STATUS = 8'hF3;

  logic [31:0]       r_mem [0:RAM_WORDS-1];
  logic [GPIO_W-1:0] r_gpio;
  logic [31:0]       r_cycle;
  logic [31:0]       r_access;
  logic [2:0]        r_status;
  logic              r_errIrq;

  logic [7:0]           w_wordIdx;
  logic [RAM_IDX_W-1:0] w_ramIdx;
  logic                 w_enabled;
  logic                 w_load;
  logic                 w_store;
  logic                 w_isRam;
  logic                 w_isGpio;
  logic                 w_isCycle;
  logic                 w_isAccess;
  logic                 w_isStatus;
  logic                 w_isMapped;
  logic [2:0]           w_setBits;
  logic [2:0]           w_clrBits;
  logic [2:0]           w_statusNext;

  // Address decode. The low two address bits never select anything; a
  // misaligned access still lands on word data_addr[9:2].
  assign w_wordIdx  = data_addr[9:2];
  assign w_ramIdx   = w_wordIdx[RAM_IDX_W-1:0];
  assign w_enabled  = ~data_cen;
  assign w_load     = w_enabled & data_wen;
  assign w_store    = w_enabled & ~data_wen;
  assign w_isRam    = ({24'd0, w_wordIdx} < 32'(RAM_WORDS));
  assign w_isGpio   = (w_wordIdx == IDX_GPIO);
  assign w_isCycle  = (w_wordIdx == IDX_CYCLE);
  assign w_isAccess = (w_wordIdx == IDX_ACCESS);
  assign w_isStatus = (w_wordIdx == IDX_STATUS);
  assign w_isMapped = w_isRam | w_isGpio | w_isCycle | w_isAccess | w_isStatus;

  // Error flags raised by this cycle's access: bit0 misalign, bit1 store to
  // a read-only counter, bit2 unmapped word. Set beats clear on the same bit.
  assign w_setBits    = {w_enabled & ~w_isMapped,
                         w_store & (w_isCycle | w_isAccess),
                         w_enabled & (data_addr[1:0] != 2'b00)};
  assign w_clrBits    = (w_store & w_isStatus) ? wdata[2:0] : 3'b000;
  assign w_statusNext = (r_status & ~w_clrBits) | w_setBits;

  // RAM array. Reset does not clear the contents; it only stops a store that
  // is in flight while reset is asserted from landing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
    end else if (w_store && w_isRam) begin
      r_mem[w_ramIdx] <= wdata;
    end
  end

  // Register window: GPIO, free-running cycle counter, access counter,
  // sticky status and the registered interrupt derived from the new status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gpio   <= '0;
      r_cycle  <= '0;
      r_access <= '0;
      r_status <= '0;
      r_errIrq <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_enabled) begin
        r_access <= r_access + 32'd1;
      end
      if (w_store && w_isGpio) begin
        r_gpio <= wdata[GPIO_W-1:0];
      end
      r_status <= w_statusNext;
      r_errIrq <= |w_statusNext;
    end
  end

  // Load mux. Idle and store cycles return 0, as do unmapped words; the
  // counters return their value before this cycle's increment.
  always_comb begin
    rdata = 32'd0;
    if (w_load) begin
      if (w_isRam) begin
        rdata = r_mem[w_ramIdx];
      end else if (w_isGpio) begin
        rdata = 32'(r_gpio);
      end else if (w_isCycle) begin
        rdata = r_cycle;
      end else if (w_isAccess) begin
        rdata = r_access;
      end else if (w_isStatus) begin
        rdata = {29'd0, r_status};
      end
    end
  end

  assign gpio_out = r_gpio;
  assign err_irq  = r_errIrq;

endmodule
